// File: rtl/vector_deconcat_rx.sv
// Byte-serial receiver: rebuilds a 32-bit word from four bytes (MSB first), unpacks
// it into six 5-bit fields plus a 2-bit trailer, and presents it on valid/ready.
//
//   state            | meaning
//   -----------------+---------------------------------------------------------
//   COLLECT cnt=0..3 | waiting for byte cnt of the next word (w, x, y, z)
//   slot FULL        | out_valid=1, a-f/out_err held until out_ready
//   (the two run independently; only byte z stalls, and only on a held slot)
module vector_deconcat_rx #(
    parameter logic [1:0] TRAILER = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_first,
    output logic       in_ready,
    output logic [4:0] a,
    output logic [4:0] b,
    output logic [4:0] c,
    output logic [4:0] d,
    output logic [4:0] e,
    output logic [4:0] f,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] err_count
);

    logic [31:0] asm_q, asm_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [29:0] fields_q, fields_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        accept;
    logic        resync;
    logic        complete;
    logic        trailer_bad;
    logic [31:0] word;

    assign in_ready    = (cnt_q != 2'd3) || !valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign resync      = accept && in_first && (cnt_q != 2'd0);
    assign complete    = accept && !resync && (cnt_q == 2'd3);
    assign word        = {asm_q[31:8], in_data};
    assign trailer_bad = complete && (in_data[1:0] != TRAILER);

    always_comb begin
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        fields_d    = fields_q;
        err_d       = err_q;
        valid_d     = valid_q;
        err_count_d = err_count_q;

        if (resync) begin
            // A start marker mid-word means the partial word is garbage.
            asm_d = {in_data, 24'h0};
            cnt_d = 2'd1;
        end else if (accept) begin
            case (cnt_q)
                2'd0:    asm_d[31:24] = in_data;
                2'd1:    asm_d[23:16] = in_data;
                2'd2:    asm_d[15:8]  = in_data;
                default: asm_d[7:0]   = in_data;
            endcase
            cnt_d = cnt_q + 2'd1;
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // A load in the drain cycle keeps the slot full with the new word.
        if (complete) begin
            fields_d = word[31:2];
            err_d    = trailer_bad;
            valid_d  = 1'b1;
        end

        if ((resync || trailer_bad) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            fields_q    <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            fields_q    <= fields_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            err_count_q <= err_count_d;
        end
    end

    assign a         = fields_q[29:25];
    assign b         = fields_q[24:20];
    assign c         = fields_q[19:15];
    assign d         = fields_q[14:10];
    assign e         = fields_q[9:5];
    assign f         = fields_q[4:0];
    assign out_err   = err_q;
    assign out_valid = valid_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_vector_deconcat_rx.sv
// Self-checking bench for vector_deconcat_rx: a word-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_vector_deconcat_rx;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_first;
    logic       in_ready;
    logic [4:0] a, b, c, d, e, f;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int valid_cycles = 0;
    int words_seen = 0;

    vector_deconcat_rx dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of bytes of the word in progress, one presentation slot.
    logic [7:0]  m_bytes[4];
    int          m_cnt;
    bit          m_full;
    logic [31:0] m_word;
    int          m_errcnt;

    function automatic logic [4:0] fld(input logic [31:0] w, input int i);
        return 5'((w >> (27 - 5 * i)) & 32'h1F);
    endfunction

    always @(negedge clk) begin
        bit exp_ready;
        logic [4:0] act_f[6];
        act_f[0] = a; act_f[1] = b; act_f[2] = c;
        act_f[3] = d; act_f[4] = e; act_f[5] = f;
        if (out_valid) valid_cycles++;
        if (!rst_n) begin
            m_cnt = 0; m_full = 0; m_word = 0; m_errcnt = 0;
            check("rst_valid", out_valid, 0);
            check("rst_err", out_err, 0);
            check("rst_errcnt", err_count, 0);
            check("rst_fields", {a, b, c, d, e, f}, 0);
            check("rst_in_ready", in_ready, 1);
        end else begin
            exp_ready = (m_cnt != 3) || !m_full || out_ready;
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, m_full);
            check("err_count", err_count, m_errcnt);
            if (m_full) begin
                for (int i = 0; i < 6; i++) check($sformatf("field%0d", i), act_f[i], fld(m_word, i));
                check("out_err", out_err, (m_word[1:0] != 2'b11));
            end
            if (m_full && out_ready) begin
                m_full = 0;
                words_seen++;
            end
            if (in_valid && exp_ready) begin
                if (in_first && m_cnt != 0) begin
                    m_bytes[0] = in_data;
                    m_cnt = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end else begin
                    m_bytes[m_cnt] = in_data;
                    if (m_cnt == 3) begin
                        m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        m_full = 1;
                        if (m_word[1:0] != 2'b11 && m_errcnt < 255) m_errcnt++;
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] dat, input logic first);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_data = dat; in_first = first; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: byte %h not accepted within 50 cycles", dat);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        valid_cycles = 0;
        words_seen = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_data = 0; in_valid = 0; in_first = 0; out_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // Test 1: minimal word, e=f=1, no error, valid for one cycle.
        do_reset();
        out_ready = 1'b1;
        send_word(32'h0000_0087);
        check("t1_valid", out_valid, 1);
        check("t1_abcd", {a, b, c, d}, 0);
        check("t1_e", e, 1);
        check("t1_f", f, 1);
        check("t1_err", out_err, 0);
        idle(5);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_errcnt", err_count, 0);

        // Test 2: bad trailer.
        send_word(32'hFFFF_FFFC);
        check("t2_fields", {a, b, c, d, e, f}, 30'h3FFF_FFFF);
        check("t2_err", out_err, 1);
        check("t2_errcnt", err_count, 1);
        idle(3);

        // Test 3: backpressure, z of word2 stalls, then same-cycle drain/load.
        do_reset();
        out_ready = 1'b0;
        send_word(32'h0000_0087);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        in_data = 8'hFF; in_first = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall", in_ready, 0);
            check("t3_hold_a", a, 0);
            check("t3_hold_e", e, 1);
            check("t3_hold_f", f, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_on_drain", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("t3_valid_kept", out_valid, 1);
        check("t3_fields", {a, b, c, d, e, f}, 30'h3FFF_FFFF);
        check("t3_err", out_err, 0);
        out_ready = 1'b1;
        idle(3);
        check("t3_words", words_seen, 2);

        // Test 4: resync discards 12 34.
        do_reset();
        out_ready = 1'b1;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        send_word(32'h0000_0087);
        idle(4);
        check("t4_errcnt", err_count, 1);
        check("t4_words", words_seen, 1);
        check("t4_last_e", e, 1);
        check("t4_last_f", f, 1);
        check("t4_last_err", out_err, 0);

        // Test 5: saturation after 260 trailer errors.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) send_word(32'hFFFF_FFFC);
        idle(3);
        check("t5_saturate", err_count, 8'hFF);
        check("t5_words", words_seen, 260);

        // Test 6: reset mid-word, then a clean word.
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b0);
        do_reset();
        idle(3);
        check("t6_no_emit", valid_cycles, 0);
        send_word(32'h0000_0087);
        check("t6_e", e, 1);
        check("t6_f", f, 1);
        idle(4);
        check("t6_words", words_seen, 1);
        check("t6_errcnt", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
